// File: rtl/rhythm_pkg.sv
// Shared types, keycodes and sprite geometry for the rhythm-game playfield lanes.
package rhythm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lane_state_t;

    localparam logic [7:0] KEY_SPACE   = 8'h2C;
    localparam logic [7:0] KEY_ESC_ACK = 8'h01;
    localparam logic [7:0] KEY_RIGHT   = 8'h4F;
    localparam logic [7:0] KEY_LEFT    = 8'h50;
    localparam logic [7:0] KEY_DOWN    = 8'h51;
    localparam logic [7:0] KEY_UP      = 8'h52;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 40;
    localparam int SPRITE_H = 40;

    // Arrow drawn along a pointing axis: a 10-px-wide shaft plus a triangular head
    // whose tip sits at the far edge of the sprite.
    function automatic logic arrow_pixel(input int dir, input int row, input int col);
        int along;
        int across;
        int off;
        logic shaft;
        logic head;
        case (dir)
            0:       begin along = col;      across = row; end
            1:       begin along = 39 - col; across = row; end
            2:       begin along = 39 - row; across = col; end
            default: begin along = row;      across = col; end
        endcase
        off   = (2 * across >= 39) ? (2 * across - 39) : (39 - 2 * across);
        shaft = (along >= 4) && (along < 24) && (across >= 15) && (across < 25);
        head  = (along >= 20) && (off <= 2 * (39 - along) + 1);
        return shaft || head;
    endfunction

endpackage

// File: rtl/arrow_sprite.sv
// Constant 40x40 arrow mask ROM, row-major with pixel (row, col) at bit row*40+col.
module arrow_sprite
    import rhythm_pkg::*;
#(
    parameter int DIR = 0
) (
    output logic [SPRITE_W*SPRITE_H-1:0] mask
);

    for (genvar r = 0; r < SPRITE_H; r++) begin : g_row
        for (genvar c = 0; c < SPRITE_W; c++) begin : g_col
            assign mask[r*SPRITE_W + c] = arrow_pixel(DIR, r, c);
        end
    end

endmodule

// File: rtl/note_lane_dropper.sv
// One playfield lane: spawns falling notes, grades key presses, counts hits/misses.
// Optional PERFECT_GRADE_EN adds a perfect-hit pulse and counter.
//
// state | meaning
// IDLE  | waiting for space to start, counts held
// RUN   | spawning, moving and grading notes
// DONE  | all notes resolved, waiting for ack key
module note_lane_dropper
    import rhythm_pkg::*;
#(
    parameter int         X_POS       = 500,
    parameter int         Y_START     = 100,
    parameter int         NOTE_H      = 40,
    parameter int         Y_HIT_TOP   = 340,
    parameter int         Y_MAX       = 400,
    parameter int         SPEED       = 1,
    parameter int         START_DELAY = 760,
    parameter int         NOTE_GAP    = 120,
    parameter int         NUM_NOTES   = 4,
    parameter logic [7:0] LANE_KEY    = KEY_RIGHT,
    parameter int         DIR         = 0
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic [7:0]                keycode,
    input  logic [7:0]                keycode_second,
    output logic [9:0]                lane_x,
    output logic [NUM_NOTES*10-1:0]   note_y,
    output logic [NUM_NOTES-1:0]      note_active,
    output logic [1599:0]             arrow_mask,
    output logic                      hit_pulse,
    output logic                      miss_pulse,
    output logic [7:0]                hit_count,
    output logic [7:0]                miss_count,
`ifdef PERFECT_GRADE_EN
    output logic                      perfect_pulse,
    output logic [7:0]                perfect_count,
`endif
    output logic                      lane_done
);

    lane_state_t                  state;
    logic [NUM_NOTES-1:0]         active_q;
    logic [NUM_NOTES-1:0][9:0]    y_q;
    logic [15:0]                  spawn_timer;
    logic [3:0]                   spawn_idx;
    logic                         key_prev;

    logic                         key_now;
    logic                         press;
    logic                         start_key;
    logic [NUM_NOTES-1:0]         oldest_sel;
    logic [9:0]                   oldest_y;
    logic [10:0]                  oldest_bottom;
    logic                         do_miss;
    logic                         do_hit;
    logic                         spawn_now;
    logic                         all_done;
    logic                         start_run;
    logic                         run_grade;

    arrow_sprite #(.DIR(DIR)) u_sprite (.mask(arrow_mask));

    assign lane_x      = 10'(X_POS);
    assign note_y      = y_q;
    assign note_active = active_q;
    assign lane_done   = (state == DONE);

    assign key_now   = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);
    assign press     = key_now && !key_prev;
    assign start_key = (keycode == KEY_SPACE) || (keycode_second == KEY_SPACE);

    // Lowest-index active slot is the oldest note; only it is graded.
    always_comb begin
        oldest_sel = '0;
        oldest_y   = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (active_q[i]) begin
                oldest_sel    = '0;
                oldest_sel[i] = 1'b1;
                oldest_y      = y_q[i];
            end
        end
    end

    assign oldest_bottom = {1'b0, oldest_y} + 11'(NOTE_H);
    assign do_miss   = (|active_q) && (oldest_bottom >= 11'(Y_MAX));
    assign do_hit    = (|active_q) && !do_miss && press && (oldest_bottom >= 11'(Y_HIT_TOP));
    assign spawn_now = (spawn_timer == '0) && (spawn_idx < 4'(NUM_NOTES));
    assign all_done  = (spawn_idx == 4'(NUM_NOTES)) && !(|active_q);
    assign start_run = (state == IDLE) && start_key;
    assign run_grade = (state == RUN) && !all_done;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state       <= IDLE;
            active_q    <= '0;
            y_q         <= '0;
            spawn_timer <= '0;
            spawn_idx   <= '0;
            key_prev    <= 1'b0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            key_prev   <= key_now;
            hit_pulse  <= run_grade && do_hit;
            miss_pulse <= run_grade && do_miss;
            case (state)
                IDLE: begin
                    if (start_key) begin
                        state       <= RUN;
                        active_q    <= '0;
                        y_q         <= '0;
                        spawn_timer <= 16'(START_DELAY);
                        spawn_idx   <= '0;
                        hit_count   <= '0;
                        miss_count  <= '0;
                    end
                end
                RUN: begin
                    if (all_done) begin
                        state <= DONE;
                    end else begin
                        if (do_miss && miss_count != 8'hFF)
                            miss_count <= miss_count + 8'd1;
                        if (do_hit && hit_count != 8'hFF)
                            hit_count <= hit_count + 8'd1;
                        for (int i = 0; i < NUM_NOTES; i++) begin
                            if ((do_miss || do_hit) && oldest_sel[i]) begin
                                active_q[i] <= 1'b0;
                                y_q[i]      <= '0;
                            end else if (active_q[i]) begin
                                y_q[i] <= y_q[i] + 10'(SPEED);
                            end else if (spawn_now && spawn_idx == 4'(i)) begin
                                active_q[i] <= 1'b1;
                                y_q[i]      <= 10'(Y_START);
                            end
                        end
                        // Down-counter reloads with GAP-1 so spawns land exactly GAP frames apart.
                        if (spawn_now) begin
                            spawn_timer <= 16'(NOTE_GAP - 1);
                            spawn_idx   <= spawn_idx + 4'd1;
                        end else if (spawn_timer != '0) begin
                            spawn_timer <= spawn_timer - 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (keycode == KEY_ESC_ACK)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERFECT_GRADE_EN
    logic perfect_now;

    assign perfect_now = do_hit && (oldest_bottom >= 11'(Y_HIT_TOP + 20))
                                && (oldest_bottom < 11'(Y_HIT_TOP + 40));

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            perfect_pulse <= 1'b0;
            perfect_count <= '0;
        end else begin
            perfect_pulse <= run_grade && perfect_now;
            if (start_run)
                perfect_count <= '0;
            else if (run_grade && perfect_now && perfect_count != 8'hFF)
                perfect_count <= perfect_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_note_lane_dropper.sv
// Directed and randomized frames for note_lane_dropper against an age-based lane model.
module tb_note_lane_dropper;

    localparam int Y_START     = 100;
    localparam int NOTE_H      = 40;
    localparam int Y_HIT_TOP   = 340;
    localparam int Y_MAX       = 400;
    localparam int SPEED       = 1;
    localparam int START_DELAY = 760;
    localparam int NOTE_GAP    = 120;
    localparam int NN          = 4;
    localparam logic [7:0] K_LANE = 8'h4F;
    localparam logic [7:0] K_GO   = 8'h2C;
    localparam logic [7:0] K_ACK  = 8'h01;

    logic         frame_clk;
    logic         Reset;
    logic [7:0]   keycode;
    logic [7:0]   keycode_second;
    logic [9:0]   lane_x;
    logic [39:0]  note_y;
    logic [3:0]   note_active;
    logic [1599:0] arrow_mask;
    logic         hit_pulse;
    logic         miss_pulse;
    logic [7:0]   hit_count;
    logic [7:0]   miss_count;
    logic         lane_done;
`ifdef PERFECT_GRADE_EN
    logic         perfect_pulse;
    logic [7:0]   perfect_count;
`endif

    note_lane_dropper dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .keycode_second (keycode_second),
        .lane_x         (lane_x),
        .note_y         (note_y),
        .note_active    (note_active),
        .arrow_mask     (arrow_mask),
        .hit_pulse      (hit_pulse),
        .miss_pulse     (miss_pulse),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`ifdef PERFECT_GRADE_EN
        .perfect_pulse  (perfect_pulse),
        .perfect_count  (perfect_count),
`endif
        .lane_done      (lane_done)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int total = 0;
    int bad   = 0;

    // Model: 0 idle, 1 run, 2 done; note k's position is a function of its age.
    int m_state = 0;
    int m_n     = 0;
    int m_hits  = 0;
    int m_miss  = 0;
    int m_perf  = 0;
    bit m_prev  = 0;
    bit m_gone [NN];
    bit e_hit, e_miss, e_perf;

    function automatic int sched(input int k);
        return START_DELAY + k * NOTE_GAP;
    endfunction

    function automatic bit live(input int k);
        return (m_state == 1) && (sched(k) < m_n) && !m_gone[k];
    endfunction

    function automatic int note_ypos(input int k);
        return Y_START + SPEED * (m_n - 1 - sched(k));
    endfunction

    task automatic model_step(input logic [7:0] k1, input logic [7:0] k2, input logic r);
        bit kn, pr, any_live;
        int oldest, bottom;
        kn = (k1 == K_LANE) || (k2 == K_LANE);
        pr = kn && !m_prev;
        e_hit = 0; e_miss = 0; e_perf = 0;
        if (r) begin
            m_state = 0; m_n = 0; m_hits = 0; m_miss = 0; m_perf = 0; m_prev = 0;
            for (int k = 0; k < NN; k++) m_gone[k] = 0;
            return;
        end
        m_prev = kn;
        case (m_state)
            0: if (k1 == K_GO || k2 == K_GO) begin
                m_state = 1; m_n = 0; m_hits = 0; m_miss = 0; m_perf = 0;
                for (int k = 0; k < NN; k++) m_gone[k] = 0;
            end
            1: begin
                any_live = 0;
                oldest = -1;
                for (int k = 0; k < NN; k++)
                    if (live(k)) begin
                        any_live = 1;
                        if (oldest < 0) oldest = k;
                    end
                if (sched(NN - 1) < m_n && !any_live) begin
                    m_state = 2;
                end else begin
                    if (oldest >= 0) begin
                        bottom = note_ypos(oldest) + NOTE_H;
                        if (bottom >= Y_MAX) begin
                            m_gone[oldest] = 1; e_miss = 1;
                            m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                        end else if (pr && bottom >= Y_HIT_TOP) begin
                            m_gone[oldest] = 1; e_hit = 1;
                            m_hits = (m_hits < 255) ? m_hits + 1 : 255;
                            if (bottom >= Y_HIT_TOP + 20 && bottom < Y_HIT_TOP + 40) begin
                                e_perf = 1;
                                m_perf = (m_perf < 255) ? m_perf + 1 : 255;
                            end
                        end
                    end
                    m_n++;
                end
            end
            default: if (k1 == K_ACK) m_state = 0;
        endcase
    endtask

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [39:0] ey;
        logic [3:0]  ea;
        ey = '0;
        ea = '0;
        for (int k = 0; k < NN; k++)
            if (live(k)) begin
                ea[k] = 1'b1;
                ey[k*10 +: 10] = 10'(note_ypos(k));
            end
        expect_eq("lane_x", lane_x, 500);
        expect_eq("note_active", note_active, ea);
        expect_eq("note_y", note_y, ey);
        expect_eq("hit_pulse", hit_pulse, e_hit);
        expect_eq("miss_pulse", miss_pulse, e_miss);
        expect_eq("hit_count", hit_count, m_hits);
        expect_eq("miss_count", miss_count, m_miss);
        expect_eq("lane_done", lane_done, m_state == 2);
`ifdef PERFECT_GRADE_EN
        expect_eq("perfect_pulse", perfect_pulse, e_perf);
        expect_eq("perfect_count", perfect_count, m_perf);
`endif
    endtask

    task automatic frame(input logic [7:0] k1, input logic [7:0] k2, input logic r);
        keycode = k1;
        keycode_second = k2;
        Reset = r;
        model_step(k1, k2, r);
        @(posedge frame_clk);
        #1;
        check_all();
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) frame(8'h00, 8'h00, 1'b0);
    endtask

    task automatic run_until_done(input logic [7:0] k1, input int budget);
        int cnt;
        cnt = 0;
        while (lane_done !== 1'b1 && cnt < budget) begin
            frame(k1, 8'h00, 1'b0);
            cnt++;
        end
        expect_eq("done_reached", lane_done, 1);
    endtask

    task automatic random_run(input int budget);
        int cnt, r;
        logic [7:0] k1, k2;
        cnt = 0;
        frame(K_GO, 8'h00, 1'b0);
        while (lane_done !== 1'b1 && cnt < budget) begin
            r  = $urandom_range(0, 7);
            k1 = 8'($urandom_range(4, 39));
            k2 = (r > 5) ? 8'h00 : 8'($urandom_range(4, 39));
            if (r == 0) k1 = K_LANE;
            if (r == 1) k2 = K_LANE;
            frame(k1, k2, 1'b0);
            cnt++;
        end
        expect_eq("rand_done_reached", lane_done, 1);
        frame(K_ACK, 8'h00, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        keycode = 8'h00;
        keycode_second = 8'h00;

        // Reset state and first note timing
        frame(8'h00, 8'h00, 1'b1);
        frame(8'h00, 8'h00, 1'b1);
        expect_eq("rst_active", note_active, 0);
        expect_eq("rst_hits", hit_count, 0);
        expect_eq("rst_done", lane_done, 0);
        expect_eq("sprite_tip", arrow_mask[19*40 + 38], 1);
        expect_eq("sprite_corner", arrow_mask[0], 0);
        frame(8'h00, 8'h00, 1'b0);
        frame(K_GO, 8'h00, 1'b0);
        idle_frames(761);
        expect_eq("spawn0_active", note_active[0], 1);
        expect_eq("spawn0_y", note_y[9:0], 100);
        idle_frames(200);
        expect_eq("move200_y", note_y[9:0], 300);
        frame(K_LANE, 8'h00, 1'b0);
        expect_eq("t1_hit_pulse", hit_pulse, 1);
        expect_eq("t1_hit_count", hit_count, 1);
        expect_eq("t1_slot0_clear", note_active[0], 0);
        run_until_done(8'h00, 1000);
        expect_eq("t1_misses", miss_count, 3);
        frame(K_ACK, 8'h00, 1'b0);
        expect_eq("t1_ack_idle", lane_done, 0);
        expect_eq("t1_hits_hold", hit_count, 1);

        // No keys: every note misses
        frame(K_GO, 8'h00, 1'b0);
        run_until_done(8'h00, 2000);
        expect_eq("t2_misses", miss_count, 4);
        expect_eq("t2_hits", hit_count, 0);
        frame(K_ACK, 8'h00, 1'b0);
        expect_eq("t2_idle", lane_done, 0);
        expect_eq("t2_misses_hold", miss_count, 4);

        // Held key grades only one note
        frame(K_GO, 8'h00, 1'b0);
        idle_frames(971);
        run_until_done(K_LANE, 2000);
        expect_eq("t3_hits", hit_count, 1);
        expect_eq("t3_misses", miss_count, 3);
        frame(K_ACK, 8'h00, 1'b0);

        // Window edges and second keycode
        frame(K_GO, 8'h00, 1'b0);
        idle_frames(960);
        frame(K_LANE, 8'h00, 1'b0);
        expect_eq("t4_early_active", note_active[0], 1);
        expect_eq("t4_early_nohit", hit_pulse, 0);
        idle_frames(59);
        frame(K_LANE, 8'h00, 1'b0);
        expect_eq("t4_late_hit", hit_pulse, 1);
        expect_eq("t4_hits", hit_count, 1);
        idle_frames(79);
        frame(K_GO, K_LANE, 1'b0);
        expect_eq("t5_second_hit", hit_pulse, 1);
        expect_eq("t5_hits", hit_count, 2);
        expect_eq("t5_slot1_clear", note_active[1], 0);
        run_until_done(8'h00, 1000);
        expect_eq("t5_misses", miss_count, 2);
        frame(K_ACK, 8'h00, 1'b0);

        // Reset mid-run
        frame(K_GO, 8'h00, 1'b0);
        idle_frames(986);
        frame(K_LANE, 8'h00, 1'b0);
        expect_eq("t6_hit", hit_pulse, 1);
`ifdef PERFECT_GRADE_EN
        expect_eq("t6_perfect", perfect_pulse, 1);
`endif
        idle_frames(23);
        expect_eq("t6_two_active", note_active, 4'b0110);
        frame(8'h00, 8'h00, 1'b1);
        expect_eq("t6_rst_active", note_active, 0);
        expect_eq("t6_rst_y", note_y, 0);
        expect_eq("t6_rst_hits", hit_count, 0);
        frame(8'h00, 8'h00, 1'b0);

        // Randomized runs
        random_run(3000);
        random_run(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
